// File: rtl/ff_convert_pkg.sv
// ff_convert_pkg: shared types and the per-bit next-state function.
//   ff_mode_t : D / T / JK / SR selection.
//   next_bit  : returns {q_next, illegal}. The illegal flag is only raised for
//               the SR S=R=1 combination, where the bit holds.
package ff_convert_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_t;

    function automatic logic [1:0] next_bit(ff_mode_t mode, logic q, logic a, logic b);
        logic nq;
        logic ill;
        nq  = q;
        ill = 1'b0;
        case (mode)
            MODE_D:  nq = a;
            MODE_T:  nq = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b00:   nq = q;
                    2'b01:   nq = 1'b0;
                    2'b10:   nq = 1'b1;
                    default: nq = ~q;
                endcase
            end
            default: begin
                case ({a, b})
                    2'b00:   nq = q;
                    2'b01:   nq = 1'b0;
                    2'b10:   nq = 1'b1;
                    default: begin
                        nq  = q;
                        ill = 1'b1;
                    end
                endcase
            end
        endcase
        return {nq, ill};
    endfunction

endpackage

// File: rtl/ff_convert_cell.sv
// ff_convert_cell: one bit of the conversion bank.
//   clk, rst (async, active-low), en : clock / reset / enable
//   mode, a, b                       : conversion mode and per-bit operands
//   q       : flop state
//   q_next  : value the flop takes on an enabled edge
//   illegal : SR S=R=1 seen on this bit (combinational)
module ff_convert_cell
    import ff_convert_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  ff_mode_t mode,
    input  logic     a,
    input  logic     b,
    output logic     q,
    output logic     q_next,
    output logic     illegal
);

    logic       q_q;
    logic       q_d;
    logic [1:0] nb;

    assign nb      = next_bit(mode, q_q, a, b);
    assign q_next  = nb[1];
    assign illegal = nb[0];
    assign q_d     = en ? q_next : q_q;
    assign q       = q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= RESET_BIT;
        else      q_q <= q_d;
    end

endmodule

// File: rtl/ff_convert_bank.sv
// ff_convert_bank: WIDTH-bit bank of mode-configurable flops.
//   clk, rst (async, active-low)  : clock / reset
//   en                            : apply next-state function (0 = everything holds)
//   mode                          : 00 D, 01 T, 10 JK, 11 SR
//   a, b                          : D/T/J/S and K/R operands
//   clr_cnt                       : synchronous clear of chg_cnt, beats increment
//   q, q_n                        : state and its complement
//   chg                           : bits that changed at the previous enabled edge
//   chg_cnt                       : saturating count of edges that changed q
//   sr_err                        : last enabled SR edge had some bit with S=R=1
module ff_convert_bank
    import ff_convert_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ff_mode_t         mode_e;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sr_err_q, sr_err_d;

    assign mode_e = ff_mode_t'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_convert_cell #(
            .RESET_BIT(RESET_VAL[i])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .mode   (mode_e),
            .a      (a[i]),
            .b      (b[i]),
            .q      (q[i]),
            .q_next (q_next[i]),
            .illegal(illegal[i])
        );
    end

    assign diff = q_next ^ q;

    always_comb begin
        chg_d    = chg_q;
        sr_err_d = sr_err_q;
        cnt_d    = cnt_q;
        if (en) begin
            chg_d    = diff;
            // illegal is only ever raised in SR mode, the mode check is kept explicit
            sr_err_d = (mode_e == MODE_SR) && (|illegal);
        end
        if (clr_cnt)
            cnt_d = '0;
        else if (en && (|diff) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_q    <= '0;
            cnt_q    <= '0;
            sr_err_q <= 1'b0;
        end else begin
            chg_q    <= chg_d;
            cnt_q    <= cnt_d;
            sr_err_q <= sr_err_d;
        end
    end

    assign q_n     = ~q;
    assign chg     = chg_q;
    assign chg_cnt = cnt_q;
    assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_ff_convert_bank.sv
module tb_ff_convert_bank;

    typedef struct {
        logic [7:0] q;
        logic [7:0] chg;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       err;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr_cnt = 1'b0;

    logic [7:0] q0, qn0, chg0, cnt0;
    logic       err0;
    logic [7:0] q1, qn1, chg1;
    logic [1:0] cnt1;
    logic       err1;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ff_convert_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
        .q(q0), .q_n(qn0), .chg(chg0), .chg_cnt(cnt0), .sr_err(err0)
    );

    // narrow counter instance, same stimulus, used for saturation
    ff_convert_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_cnt(clr_cnt),
        .q(q1), .q_n(qn1), .chg(chg1), .chg_cnt(cnt1), .sr_err(err1)
    );

    always @(posedge clk) begin
        if (rst && en) assert (!$isunknown(mode)) else $error("mode is X/Z while enabled");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // monitor: one expected entry per enabled/disabled stimulus edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".q"},      q0,                e.q);
            chk({e.tag, ".q_n"},    qn0,               ~e.q);
            chk({e.tag, ".chg"},    chg0,              e.chg);
            chk({e.tag, ".cnt"},    cnt0,              e.cnt);
            chk({e.tag, ".cnt2"},   {6'b0, cnt1},      {6'b0, e.cnt2});
            chk({e.tag, ".sr_err"}, {7'b0, err0},      {7'b0, e.err});
        end
    end

    task automatic step(input logic e_en, input logic [1:0] m, input logic [7:0] av,
                        input logic [7:0] bv, input logic c,
                        input logic [7:0] eq, input logic [7:0] echg, input logic [7:0] ecnt,
                        input logic [1:0] ec2, input logic eerr, input string tag);
        exp_t x;
        @(negedge clk);
        en = e_en; mode = m; a = av; b = bv; clr_cnt = c;
        x.q = eq; x.chg = echg; x.cnt = ecnt; x.cnt2 = ec2; x.err = eerr; x.tag = tag;
        exp_q.push_back(x);
    endtask

    initial begin
        // asynchronous reset between edges
        #3 rst = 1'b0;
        #1;
        chk("rst.q",      q0,  8'hA5);
        chk("rst.chg",    chg0, 8'h00);
        chk("rst.cnt",    cnt0, 8'h00);
        chk("rst.sr_err", {7'b0, err0}, 8'h00);
        chk("rst.q2",     q1,  8'h00);
        #8 rst = 1'b1;

        //   en    mode   a      b      clr   q      chg    cnt    c2     err
        step(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0, 8'h3C, 8'h99, 8'd1,  2'd1, 1'b0, "d_load");
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h3C, 8'd2,  2'd2, 1'b0, "d_zero");
        step(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'd3,  2'd3, 1'b0, "t1");
        step(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 8'd4,  2'd3, 1'b0, "t2");
        step(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'd5,  2'd3, 1'b0, "t3");
        step(1'b0, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'd5,  2'd3, 1'b0, "hold1");
        step(1'b0, 2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 8'd5,  2'd3, 1'b0, "hold2");
        step(1'b1, 2'b00, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'h0F, 8'd6,  2'd3, 1'b0, "d_f0");
        step(1'b1, 2'b10, 8'h0C, 8'h30, 1'b0, 8'hCC, 8'h3C, 8'd7,  2'd3, 1'b0, "jk_mix");
        step(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'h33, 8'hFF, 8'd8,  2'd3, 1'b0, "jk_tog");
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h33, 8'd9,  2'd3, 1'b0, "d_clr");
        step(1'b1, 2'b11, 8'h81, 8'h01, 1'b0, 8'h80, 8'h80, 8'd10, 2'd3, 1'b1, "sr_ill");
        step(1'b1, 2'b11, 8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'd11, 2'd3, 1'b0, "sr_rst");
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'd11, 2'd3, 1'b0, "no_chg");
        step(1'b1, 2'b11, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 8'd11, 2'd3, 1'b1, "sr_ill0");
        step(1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'd11, 2'd3, 1'b1, "err_hold");
        step(1'b0, 2'b00, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 8'd0,  2'd0, 1'b1, "clr_dis");
        step(1'b1, 2'b00, 8'h55, 8'h00, 1'b1, 8'h55, 8'h55, 8'd0,  2'd0, 1'b0, "clr_win");
        step(1'b1, 2'b00, 8'hAA, 8'h00, 1'b0, 8'hAA, 8'hFF, 8'd1,  2'd1, 1'b0, "d_aa");
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 8'hAA, 8'd2,  2'd2, 1'b0, "d_00");
        step(1'b1, 2'b00, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'd3,  2'd3, 1'b0, "sw_d");
        step(1'b1, 2'b01, 8'h0F, 8'h00, 1'b0, 8'h00, 8'h0F, 8'd4,  2'd3, 1'b0, "sw_t");
        step(1'b1, 2'b10, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'd5,  2'd3, 1'b0, "sw_jk");

        // mid-sequence async reset
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst2.q",      q0,   8'hA5);
        chk("rst2.chg",    chg0, 8'h00);
        chk("rst2.cnt",    cnt0, 8'h00);
        chk("rst2.sr_err", {7'b0, err0}, 8'h00);
        chk("rst2.cnt2",   {6'b0, cnt1}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2'b00, 8'h12, 8'h00, 1'b0, 8'h12, 8'hB7, 8'd1,  2'd1, 1'b0, "post_rst");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
